// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and defaults.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding slot for a fetched word that IF/ID cannot take yet.
module fetch_skid_buf #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic            pop,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d;

    always_comb begin
        valid_d = clear ? 1'b0 : load ? 1'b1 : pop ? 1'b0 : valid_q;
        pc_d    = load ? load_pc : pc_q;
        instr_d = load ? load_instr : instr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with a one-deep skid buffer, branch redirect, and a drain
// state that swallows the response of a request abandoned by a taken branch.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            take_branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            flush_id,
    output logic            flush_ex
);
    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, drain_addr_q, drain_addr_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
    logic            skid_valid, skid_load, skid_pop;
    logic [XLEN-1:0] skid_pc, skid_instr, target;
    logic            xfer, fetch_xfer, if_load, if_fill;

    assign xfer       = imem_req && imem_ready;
    assign fetch_xfer = xfer && (state_q == FETCH);
    assign if_load    = !(if_valid_q && stall);
    assign target     = branch_target & ~XLEN'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // A branch that catches a request mid-handshake must let it finish at the old address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = (take_branch && imem_req && !imem_ready) ? DRAIN : FETCH;
            DRAIN:   state_d = xfer ? FETCH : DRAIN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == DRAIN) || (state_q == FETCH && !skid_valid);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
        flush_id  = take_branch && rst_n;
        flush_ex  = take_branch && rst_n;
    end

    always_comb begin
        pc_d         = take_branch ? target : fetch_xfer ? pc_q + XLEN'(4) : pc_q;
        drain_addr_d = (state_q == DRAIN) ? drain_addr_q : pc_q;
        skid_load    = !take_branch && fetch_xfer && !if_load;
        skid_pop     = !take_branch && if_load && skid_valid;
        if_fill      = !take_branch && if_load && fetch_xfer;
        if_valid_d   = take_branch ? 1'b0 : if_load ? (skid_valid || fetch_xfer) : if_valid_q;
        if_pc_d      = skid_pop ? skid_pc : if_fill ? pc_q : if_pc_q;
        if_instr_d   = skid_pop ? skid_instr : if_fill ? imem_rdata : if_instr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (take_branch),
        .load       (skid_load),
        .pop        (skid_pop),
        .load_pc    (pc_q),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, hand-written corner sequences, and a random run
// checked against an instruction-stream model of the fetch stage.
module tb_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        take_branch = 1'b0, stall = 1'b0, imem_ready = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req, if_valid, flush_id, flush_ex;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;
    int          vectors = 0, miscompares = 0;

    typedef struct {
        logic        stall, ready, br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic        flush;
    } vec_t;
    vec_t tbl[12];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .take_branch(take_branch), .branch_target(branch_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush_id(flush_id), .flush_ex(flush_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic b, input logic [31:0] t);
        @(negedge clk);
        stall = s; imem_ready = r; take_branch = b; branch_target = t;
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk1({tag, "_if_valid"}, if_valid, 1'b0);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
        chk({tag, "_if_instr"}, if_instr, 32'h0);
        chk1({tag, "_flush_id"}, flush_id, 1'b0);
        chk1({tag, "_flush_ex"}, flush_ex, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b0; take_branch = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        p_req, p_ready, p_br, p_vld, p_stall, s, r, b;
        logic [31:0] p_addr, p_tgt, p_pc, p_instr, t, exp_pc;
        int          consumed;

        // stall, ready, br, tgt | req, addr | vld, pc | flush
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 32'h14,  1'b1, 32'h10,  1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].stall, tbl[i].ready, tbl[i].br, tbl[i].tgt);
            chk1($sformatf("row%0d_req", i), imem_req, tbl[i].req);
            if (tbl[i].req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
            chk1($sformatf("row%0d_if_valid", i), if_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("row%0d_if_pc", i), if_pc, tbl[i].pc);
                chk($sformatf("row%0d_if_instr", i), if_instr, mem_word(tbl[i].pc));
            end
            chk1($sformatf("row%0d_flush_id", i), flush_id, tbl[i].flush);
            chk1($sformatf("row%0d_flush_ex", i), flush_ex, tbl[i].flush);
        end

        // Branch while a request waits: old address held, its data dropped.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h20);
        chk1("seq_a_flush", flush_id, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_a_addr20", imem_addr, 32'h20);
        chk1("seq_a_kill_valid", if_valid, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h200);
        chk1("drain_flush_ex", flush_ex, 1'b1);
        chk("drain_addr_c2", imem_addr, 32'h20);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk1("drain_req_c3", imem_req, 1'b1);
        chk("drain_addr_c3", imem_addr, 32'h20);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_addr_c4", imem_addr, 32'h20);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_new_addr", imem_addr, 32'h200);
        chk1("drain_discard", if_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_if_pc", if_pc, 32'h200);
        chk("drain_if_instr", if_instr, mem_word(32'h200));

        // Branch in the same cycle as a completed transfer at 0x40.
        cyc(1'b0, 1'b1, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b1, 32'h80);
        chk("same_cycle_addr40", imem_addr, 32'h40);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("same_cycle_next_addr", imem_addr, 32'h80);
        chk1("same_cycle_no_40", if_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("same_cycle_if_pc", if_pc, 32'h80);

        // Asynchronous reset with IF/ID full and 0x30 outstanding.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h2C);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_reset_addr", imem_addr, 32'h30);
        chk("pre_reset_if_pc", if_pc, 32'h2C);
        #2 rst_n = 1'b0; take_branch = 1'b1;
        #1 check_reset("async_reset");
        take_branch = 1'b0; imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk1("post_reset_boot_req", imem_req, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk1("post_reset_valid", if_valid, 1'b0);
        chk("post_reset_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_reset_if_pc", if_pc, 32'h0);

        // Random run: IF/ID must deliver exactly the program-order stream from the last redirect.
        do_reset();
        p_req = 1'b0; p_ready = 1'b0; p_br = 1'b0; p_vld = 1'b0; p_stall = 1'b0;
        p_addr = '0; p_tgt = '0; p_pc = '0; p_instr = '0;
        exp_pc = 32'h0; consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) != 0);
            b = (i >= 2) && ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 4095));
            cyc(s, r, b, t);
            chk1("rnd_flush_id", flush_id, b);
            chk1("rnd_flush_ex", flush_ex, b);
            if (p_req && !p_ready) begin
                chk1("rnd_req_held", imem_req, 1'b1);
                chk("rnd_addr_held", imem_addr, p_addr);
            end
            if (p_br && !(p_req && !p_ready)) begin
                chk1("rnd_br_latency_req", imem_req, 1'b1);
                chk("rnd_br_latency_addr", imem_addr, {p_tgt[31:2], 2'b00});
            end
            if (p_br) chk1("rnd_br_kill", if_valid, 1'b0);
            else if (p_vld && p_stall) begin
                chk1("rnd_hold_valid", if_valid, 1'b1);
                chk("rnd_hold_pc", if_pc, p_pc);
                chk("rnd_hold_instr", if_instr, p_instr);
            end
            if (if_valid && !s && !b) begin
                chk("rnd_stream_pc", if_pc, exp_pc);
                chk("rnd_stream_instr", if_instr, mem_word(exp_pc));
                exp_pc = (if_pc !== exp_pc) ? if_pc + 32'd4 : exp_pc + 32'd4;
                consumed++;
            end
            if (b) exp_pc = {t[31:2], 2'b00};
            p_req = imem_req; p_ready = r; p_addr = imem_addr; p_br = b; p_tgt = t;
            p_vld = if_valid; p_stall = s; p_pc = if_pc; p_instr = if_instr;
        end
        chk1("rnd_progress", consumed >= 300, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
